hack_cpu_sequencer: RTL and testbench
=====================================

Name: hack_cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the Hack CPU datapath.
- Fetches each 16-bit instruction over a req/ack instruction-memory port and decodes A- versus C-instructions.
- Sequences optional data-memory read and write phases, and pulses the A, D and ALU register strobes.
- Evaluates the jump condition from latched ALU flags, then updates the PC. The ALU, A and D registers remain in the existing datapath.

Parameters:
- PC_W, 15, width of the PC and of instruction/data addresses.
- DATA_W, 16, instruction and data word width. Fixed at 16 for Hack encoding.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  allows a new fetch when high; sampled in IDLE and WB.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_rdata  in  DATA_W  instruction word; valid when imem_ack is high.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = write (M := ALU out), 0 = read.
- dmem_addr  out  PC_W  equal to a_in[PC_W-1:0].
- dmem_ack  in  1  data access complete.
- m_capture  out  1  one-cycle pulse; the datapath latches dmem read data into its M operand register.
- a_in  in  DATA_W  current A register value.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- instr  out  DATA_W  latched instruction register.
- alu_en  out  1  EXEC-phase strobe.
- load_a  out  1  A register write pulse.
- a_sel_instr  out  1  with load_a: 1 = A := instr[14:0] zero-extended, 0 = A := ALU out.
- load_d  out  1  D register write pulse.
- pc  out  PC_W  program counter.
- retire  out  1  one-cycle pulse per completed instruction.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=0, instr=0.
  - All strobes, reqs, retire and busy are 0 immediately, including mid-transaction. Requests are dropped with no completion.
- States: IDLE, FETCH, DECODE, MRD, EXEC, MWR, WB.
- IDLE: if run=1 go to FETCH, else stay.
- FETCH:
  - imem_req=1, imem_addr=pc; both held stable until imem_ack=1 is sampled. Zero-wait ack in the first FETCH cycle is legal.
  - On ack: instr<=imem_rdata, then go to DECODE.
- DECODE (1 cycle):
  - instr[15]=0 (A-instruction): go to WB.
  - C-instruction with a-bit instr[12]=1: go to MRD.
  - Otherwise: go to EXEC.
- MRD:
  - dmem_req=1, dmem_we=0, held until dmem_ack.
  - On ack: m_capture=1 for that cycle, then go to EXEC.
- EXEC (1 cycle):
  - alu_en=1.
  - Latch zr_q<=alu_zr, ng_q<=alu_ng, and a_q<=a_in (jump target).
  - If d3 (instr[3]) = 1 go to MWR, else go to WB.
- MWR:
  - dmem_req=1, dmem_we=1, held until dmem_ack, then go to WB.
  - The datapath holds ALU inputs, so ALU out is stable.
- WB (1 cycle), A-instruction:
  - load_a=1, a_sel_instr=1.
  - pc<=pc+1.
- WB (1 cycle), C-instruction:
  - load_a=d1 (instr[5]), a_sel_instr=0, load_d=d2 (instr[4]).
  - jump evaluated on j=instr[2:0] with zr_q/ng_q:
    - 000 never.
    - 001 !zr&!ng.
    - 010 zr.
    - 011 !ng.
    - 100 ng.
    - 101 !zr.
    - 110 zr|ng.
    - 111 always.
  - pc <= jump ? a_q[PC_W-1:0] : pc+1. The target is the A value before this instruction's writeback.
- WB, common to both instruction types:
  - retire=1.
  - Next state FETCH if run=1, else IDLE.
- PC arithmetic: modulo 2^PC_W; 0x7FFF+1 wraps to 0x0000.
- Out-of-state acks: imem_ack outside FETCH and dmem_ack outside MRD/MWR are ignored.
- M read and write in one instruction: MRD precedes EXEC; MWR follows it.
- run deasserted mid-instruction: the instruction completes; the stop takes effect at WB.
- Latency with zero-wait memory (FETCH to retire inclusive):
  - A-instruction: 3 cycles.
  - C-instruction: 4 cycles, plus 1 each for MRD and MWR.

Test Plan:
- Reset, then run=1, imem returns 0x0005 with zero wait → FETCH, DECODE, WB; load_a=1 and a_sel_instr=1 in WB; pc 0→1; retire after 3 cycles.
- C-instruction 0xEC10 (D=A), a_in=0x0005, zr=0, ng=0 → EXEC then WB with load_d=1 and load_a=0; pc=pc+1; no dmem activity.
- 0xFC08 (M=M), imem ack delayed 2 cycles, dmem_ack delayed 3 cycles in both MRD and MWR → imem_req held 3 cycles; MRD with m_capture pulse on ack; EXEC; MWR with dmem_we=1 held 4 cycles; retire once.
- Sweep jump 0xE301..0xE307 (D;JGT..JMP) with (zr,ng) ∈ {(0,0),(1,0),(0,1)}, a_in=0x1234 → pc=0x1234 exactly per the jump table, else pc+1; 0xE300 never jumps.
- pc=0x7FFF executing an A-instruction → pc=0x0000 after WB.
- rst_n low during MWR with dmem_req=1 → dmem_req=0 asynchronously, pc=0, state IDLE, no retire; recovers normally after release.
- run dropped during EXEC → instruction retires, state goes to IDLE, busy=0, imem_req stays 0.

Source files
------------

// File: rtl/hack_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// hack_cpu_sequencer
//
// Multi-cycle fetch/decode/execute controller for the Hack CPU datapath.
// The block fetches each instruction over a req/ack instruction port and
// decodes it. It sequences optional data-memory read and write phases,
// pulses the A/D/ALU strobes, evaluates the jump condition and updates
// the PC. The ALU, A and D registers themselves live in the datapath.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   run_i                 permits a new fetch (sampled in IDLE and WB)
//   imem_req_o/addr_o     instruction fetch request / address (= pc)
//   imem_rdata_i/ack_i    instruction word / fetch complete
//   dmem_req_o/we_o       data access request / 1 = write, 0 = read
//   dmem_addr_o           data address (= A register low bits)
//   dmem_ack_i            data access complete
//   m_capture_o           pulse: datapath latches dmem read data into M
//   a_i                   current A register value
//   alu_zr_i, alu_ng_i    ALU zero / negative flags
//   instr_o               latched instruction register
//   alu_en_o              EXEC-phase strobe
//   load_a_o, a_sel_instr_o  A write pulse / 1 = A := instr[14:0]
//   load_d_o              D write pulse
//   pc_o                  program counter
//   retire_o              one pulse per completed instruction
//   busy_o                high in every state except IDLE
// ---------------------------------------------------------------------------
module hack_cpu_sequencer #(
  parameter int PC_W   = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  output logic              imem_req_o,
  output logic [PC_W-1:0]   imem_addr_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              imem_ack_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [PC_W-1:0]   dmem_addr_o,
  input  logic              dmem_ack_i,
  output logic              m_capture_o,
  input  logic [DATA_W-1:0] a_i,
  input  logic              alu_zr_i,
  input  logic              alu_ng_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              alu_en_o,
  output logic              load_a_o,
  output logic              a_sel_instr_o,
  output logic              load_d_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              retire_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MRD    = 3'd3,
    S_EXEC   = 3'd4,
    S_MWR    = 3'd5,
    S_WB     = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic                zr_q, zr_d;
  logic                ng_q, ng_d;
  logic [PC_W-1:0]     a_q, a_d;

  // Only the low PC_W bits of A ever address memory or serve as a target.
  logic unused_a_hi;
  assign unused_a_hi = ^a_i[DATA_W-1:PC_W];

  // Hack jump table: j = {j1(<0), j2(=0), j3(>0)}.
  function automatic logic jump_taken(input logic [2:0] j,
                                      input logic zr, input logic ng);
    logic t;
    case (j)
      3'b000:  t = 1'b0;
      3'b001:  t = ~zr & ~ng;
      3'b010:  t = zr;
      3'b011:  t = ~ng;
      3'b100:  t = ng;
      3'b101:  t = ~zr;
      3'b110:  t = zr | ng;
      default: t = 1'b1;
    endcase
    return t;
  endfunction

  // State and datapath-control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      a_q     <= a_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    a_d     = a_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack_i) begin
          instr_d = imem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!instr_q[15])     state_d = S_WB;
        else if (instr_q[12]) state_d = S_MRD;
        else                  state_d = S_EXEC;
      end
      S_MRD: begin
        if (dmem_ack_i) state_d = S_EXEC;
      end
      S_EXEC: begin
        // Flags and A are frozen here so WB sees the pre-writeback values.
        zr_d    = alu_zr_i;
        ng_d    = alu_ng_i;
        a_d     = a_i[PC_W-1:0];
        state_d = instr_q[3] ? S_MWR : S_WB;
      end
      S_MWR: begin
        if (dmem_ack_i) state_d = S_WB;
      end
      S_WB: begin
        if (instr_q[15] && jump_taken(instr_q[2:0], zr_q, ng_q))
          pc_d = a_q;
        else
          pc_d = pc_q + PC_W'(1);
        state_d = run_i ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    imem_req_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_we_o     = 1'b0;
    m_capture_o   = 1'b0;
    alu_en_o      = 1'b0;
    load_a_o      = 1'b0;
    a_sel_instr_o = 1'b0;
    load_d_o      = 1'b0;
    retire_o      = 1'b0;
    case (state_q)
      S_FETCH: imem_req_o = 1'b1;
      S_MRD: begin
        dmem_req_o  = 1'b1;
        m_capture_o = dmem_ack_i;
      end
      S_EXEC: alu_en_o = 1'b1;
      S_MWR: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = 1'b1;
      end
      S_WB: begin
        retire_o = 1'b1;
        if (!instr_q[15]) begin
          load_a_o      = 1'b1;
          a_sel_instr_o = 1'b1;
        end else begin
          load_a_o = instr_q[5];
          load_d_o = instr_q[4];
        end
      end
      default: ;
    endcase
  end

  assign imem_addr_o = pc_q;
  assign dmem_addr_o = a_i[PC_W-1:0];
  assign instr_o     = instr_q;
  assign pc_o        = pc_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_hack_cpu_sequencer.sv
module tb_hack_cpu_sequencer;
  localparam int PC_W   = 15;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ack;
  logic              dmem_req;
  logic              dmem_we;
  logic [PC_W-1:0]   dmem_addr;
  logic              dmem_ack;
  logic              m_capture;
  logic [DATA_W-1:0] a_in;
  logic              alu_zr;
  logic              alu_ng;
  logic [DATA_W-1:0] instr;
  logic              alu_en;
  logic              load_a;
  logic              a_sel_instr;
  logic              load_d;
  logic [PC_W-1:0]   pc;
  logic              retire;
  logic              busy;

  hack_cpu_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rdata_i(imem_rdata), .imem_ack_i(imem_ack),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
    .dmem_ack_i(dmem_ack), .m_capture_o(m_capture),
    .a_i(a_in), .alu_zr_i(alu_zr), .alu_ng_i(alu_ng),
    .instr_o(instr), .alu_en_o(alu_en), .load_a_o(load_a),
    .a_sel_instr_o(a_sel_instr), .load_d_o(load_d),
    .pc_o(pc), .retire_o(retire), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [PC_W-1:0] exp_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Hack semantics: j2 selects "<0", j1 selects "=0", j0 selects ">0".
  // Only flag combinations a real ALU can produce are used as stimulus.
  function automatic bit ref_jump(input logic [2:0] j, input bit zr, input bit ng);
    bit positive;
    positive = !zr && !ng;
    return (j[2] && ng) || (j[1] && zr) || (j[0] && positive);
  endfunction

  // Executes one instruction with the given memory wait states and checks
  // strobes, phase lengths, latency and the resulting PC.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] av,
                           input bit zr, input bit ng,
                           input int iw, input int dwr, input int dww,
                           input bit abort, input bit drop_run);
    bit is_a, rd, wr, done, started;
    int cyc, n_if, n_rd, n_wr, n_cap, n_alu, exp_cyc;
    logic [PC_W-1:0] nxt;
    is_a = !ins[15];
    rd   = ins[15] && ins[12];
    wr   = ins[15] && ins[3];
    if (!is_a && ref_jump(ins[2:0], zr, ng)) nxt = av[PC_W-1:0];
    else                                     nxt = exp_pc + 1'b1;
    exp_cyc = (iw + 1) + 1 + (rd ? dwr + 1 : 0) + (is_a ? 0 : 1)
            + (wr ? dww + 1 : 0) + 1;
    done = 0; started = 0;
    cyc = 0; n_if = 0; n_rd = 0; n_wr = 0; n_cap = 0; n_alu = 0;
    a_in = av; alu_zr = zr; alu_ng = ng;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (imem_req) started = 1;
      if (started) cyc++;
      imem_ack   = 1'b0;
      dmem_ack   = 1'b0;
      imem_rdata = 16'($urandom);
      if (imem_req) begin
        if (n_if == iw) begin
          imem_ack   = 1'b1;
          imem_rdata = ins;
          chk("imem_addr", 32'(imem_addr), 32'(exp_pc));
        end
        n_if++;
      end else if ($urandom_range(0, 3) == 0) begin
        imem_ack = 1'b1;
      end
      if (dmem_req && !dmem_we) begin
        if (n_rd == dwr) dmem_ack = 1'b1;
        n_rd++;
      end else if (dmem_req && dmem_we) begin
        if (abort) begin
          rst_n = 1'b0;
          #1;
          chk("rst_dmem_req", 32'(dmem_req), 0);
          chk("rst_pc", 32'(pc), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_retire", 32'(retire), 0);
          exp_pc = '0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        if (n_wr == dww) begin
          dmem_ack = 1'b1;
          chk("dmem_addr", 32'(dmem_addr), 32'(av[PC_W-1:0]));
        end
        n_wr++;
      end else if ($urandom_range(0, 3) == 0) begin
        dmem_ack = 1'b1;
      end
      if (alu_en) begin
        n_alu++;
        if (drop_run) run = 1'b0;
      end
      #1;
      if (m_capture) n_cap++;
      if (retire) begin
        done = 1;
        chk("load_a", 32'(load_a), is_a ? 1 : 32'(ins[5]));
        chk("a_sel",  32'(a_sel_instr), is_a ? 1 : 0);
        chk("load_d", 32'(load_d), is_a ? 0 : 32'(ins[4]));
        chk("instr",  32'(instr), 32'(ins));
      end
    end
    if (!done) begin
      chk("retire_timeout", 0, 1);
    end else begin
      chk("latency", cyc, exp_cyc);
      chk("imem_cycles", n_if, iw + 1);
      chk("mrd_cycles", n_rd, rd ? dwr + 1 : 0);
      chk("mwr_cycles", n_wr, wr ? dww + 1 : 0);
      chk("m_capture", n_cap, rd ? 1 : 0);
      chk("alu_en", n_alu, is_a ? 0 : 1);
      @(posedge clk);
      #1;
      chk("pc", 32'(pc), 32'(nxt));
      exp_pc = nxt;
    end
  endtask

  initial begin
    bit zr, ng;
    int sel;
    rst_n = 1'b0; run = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;
    dmem_ack = 1'b0; a_in = '0; alu_zr = 1'b0; alu_ng = 1'b0;
    exp_pc = '0;
    #1;
    chk("reset_pc", 32'(pc), 0);
    chk("reset_instr", 32'(instr), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_imem_req", 32'(imem_req), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    run = 1'b1;

    // Directed scenarios
    run_instr(16'h0005, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    run_instr(16'hEC10, 16'h0005, 0, 0, 0, 0, 0, 0, 0);
    run_instr(16'hFC08, 16'h0040, 0, 0, 2, 3, 3, 0, 0);
    for (int j = 0; j < 8; j++) begin
      for (int f = 0; f < 3; f++) begin
        run_instr(16'hE300 | 16'(j), 16'h1234, f == 1, f == 2, 0, 0, 0, 0, 0);
      end
    end
    run_instr(16'hE307, 16'h7FFF, 0, 0, 0, 0, 0, 0, 0);
    run_instr(16'h0005, 16'h7FFF, 0, 0, 1, 0, 0, 0, 0);
    chk("pc_wrap", 32'(pc), 0);

    // Reset in the middle of a write phase, then recovery
    run_instr(16'hE308, 16'h0077, 0, 0, 0, 0, 2, 1, 0);
    run_instr(16'h0123, 16'h0000, 0, 0, 0, 0, 0, 0, 0);

    // run dropped during EXEC: instruction completes, sequencer parks
    run_instr(16'hE318, 16'h0010, 0, 0, 1, 0, 1, 0, 1);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_imem_req", 32'(imem_req), 0);
    repeat (3) @(negedge clk);
    chk("stop_idle_req", 32'(imem_req), 0);
    chk("stop_pc_hold", 32'(pc), 32'(exp_pc));
    run = 1'b1;

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 2);
      zr = (sel == 1);
      ng = (sel == 2);
      run_instr(16'($urandom), 16'($urandom), zr, ng,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
